// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 keyboard receiver.
//   state_t   : frame FSM states (IDLE, DATA, PARITY, STOP)
//   err_t     : ERR_CODE encodings (none, parity, stop, timeout)
//   BYTE_E0/F0: extended / break prefix bytes, PREFIX_EF for both together
//   prefix_of : maps the ext/brk flags onto the 8-bit prefix of a code
// -----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_PARITY  = 2'b01,
    ERR_STOP    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

  localparam logic [7:0] BYTE_E0   = 8'hE0;
  localparam logic [7:0] BYTE_F0   = 8'hF0;
  localparam logic [7:0] PREFIX_EF = 8'hEF;

  function automatic logic [7:0] prefix_of(input logic ext, input logic brk);
    logic [7:0] p;
    p = 8'h00;
    if (ext && brk) p = PREFIX_EF;
    else if (ext)   p = BYTE_E0;
    else if (brk)   p = BYTE_F0;
    return p;
  endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// -----------------------------------------------------------------------------
// ps2_code_fifo
// Synchronous FIFO for assembled 16-bit key codes.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, push_data: write request and data (dropped when full, unless a pop
//                    is accepted in the same cycle)
//   pop            : read request, ignored when empty
//   head           : current head entry, 0 when empty
//   valid, full    : non-empty / holds DEPTH entries
//   overflow       : sticky drop flag, cleared by the next accepted pop
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ps2_code_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && valid;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign push_ok = push && (!full || pop_ok);
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      if (pop_ok)                overflow <= 1'b0;
      else if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; head is masked to 0 while empty, so stale
  // contents are never visible and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// PS/2 keyboard receiver running entirely in the CLOCK domain.
//   CLOCK, rst_n          : system clock, asynchronous active-low reset
//   PS2_KBCLK, PS2_KBDAT  : raw PS/2 lines (asynchronous, synchronised here)
//   code_rd               : pop the FIFO head (ignored while code_valid=0)
//   code_vector           : FIFO head, [15:8] prefix, [7:0] code
//   code_valid, fifo_full : FIFO non-empty / FIFO full
//   overflow              : sticky, a code was dropped on a full FIFO
//   ERR_CODE              : last frame error (00 none, 01 parity, 10 stop,
//                           11 timeout)
// Compile-time option: define PS2_RX_TIMEOUT_EN to build the inter-strobe
// timeout counter; without it the frame FSM waits indefinitely.
// -----------------------------------------------------------------------------
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        CLOCK,
  input  logic        rst_n,
  input  logic        PS2_KBCLK,
  input  logic        PS2_KBDAT,
  input  logic        code_rd,
  output logic [15:0] code_vector,
  output logic        code_valid,
  output logic        fifo_full,
  output logic        overflow,
  output logic [1:0]  ERR_CODE
);

  localparam int unsigned   FW       = $clog2(FILTER_LEN);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  // ---------------- synchroniser ----------------
  logic kbclk_s1, kbclk_s2, kbdat_s1, kbdat_s2;

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      kbclk_s1 <= 1'b1;
      kbclk_s2 <= 1'b1;
      kbdat_s1 <= 1'b1;
      kbdat_s2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make this a true two-stage shift;
      // blocking ones would collapse both flops into one.
      kbclk_s1 <= PS2_KBCLK;
      kbclk_s2 <= kbclk_s1;
      kbdat_s1 <= PS2_KBDAT;
      kbdat_s2 <= kbdat_s1;
    end
  end

  // ---------------- glitch filter and strobe ----------------
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          strobe;

  // flt_cnt counts consecutive samples that disagree with clk_filt; the
  // FILTER_LEN-th such sample flips the level. A 1->0 flip is the strobe.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      strobe   <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (kbclk_s2 == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        flt_cnt  <= '0;
        clk_filt <= kbclk_s2;
        strobe   <= clk_filt;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  // ---------------- frame FSM ----------------
  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  err_t       err, err_n;
  logic       byte_vld, byte_vld_n;
  logic       abort;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  // A strobe in the expiry cycle still counts as in time.
  assign to_hit = (state != ST_IDLE) && !strobe &&
                  (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n)                           to_cnt <= '0;
    else if (state == ST_IDLE || strobe)  to_cnt <= '0;
    else                                  to_cnt <= to_cnt + TW'(1);
  end
`endif

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      err      <= ERR_NONE;
      byte_vld <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      err      <= err_n;
      byte_vld <= byte_vld_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    err_n      = err;
    byte_vld_n = 1'b0;
    abort      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (strobe && !kbdat_s2) begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
          err_n     = ERR_NONE;
        end
      end
      ST_DATA: begin
        if (strobe) begin
          shift_n   = {kbdat_s2, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (strobe) begin
          if (^{shift, kbdat_s2}) begin
            state_n = ST_STOP;
          end else begin
            state_n = ST_IDLE;
            err_n   = ERR_PARITY;
            abort   = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (strobe) begin
          state_n = ST_IDLE;
          if (kbdat_s2) begin
            byte_vld_n = 1'b1;
          end else begin
            err_n = ERR_STOP;
            abort = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

`ifdef PS2_RX_TIMEOUT_EN
    if (to_hit) begin
      state_n = ST_IDLE;
      err_n   = ERR_TIMEOUT;
      abort   = 1'b1;
    end
`endif
  end

  assign ERR_CODE = err;

  // ---------------- code assembler ----------------
  // byte_vld fires the cycle after the stop strobe; shift still holds the
  // byte then because the next strobe is at least 2*FILTER_LEN cycles away.
  logic        ext, brk;
  logic        push;
  logic [15:0] push_data;

  assign push      = byte_vld && (shift != BYTE_E0) && (shift != BYTE_F0);
  assign push_data = {prefix_of(ext, brk), shift};

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (abort) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_vld) begin
      if (shift == BYTE_E0) begin
        ext <= 1'b1;
      end else if (shift == BYTE_F0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  // ---------------- code FIFO ----------------
  ps2_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (CLOCK),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (code_rd),
    .head      (code_vector),
    .valid     (code_valid),
    .full      (fifo_full),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_ps2_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_rx
// Self-checking bench for ps2_rx. PS/2 frames are bit-banged on the raw lines
// and the received codes are compared against a byte-level reference model
// (prefix flags plus a queue of expected FIFO contents).
// -----------------------------------------------------------------------------
module tb_ps2_rx;

  localparam int FILTER_LEN     = 4;
  localparam int FIFO_DEPTH     = 8;
  localparam int TIMEOUT_CYCLES = 3000;
  localparam int HALF           = 20;   // CLOCK cycles per PS/2 half period

  logic        CLOCK = 1'b0;
  logic        rst_n = 1'b0;
  logic        PS2_KBCLK = 1'b1;
  logic        PS2_KBDAT = 1'b1;
  logic        code_rd = 1'b0;
  logic [15:0] code_vector;
  logic        code_valid;
  logic        fifo_full;
  logic        overflow;
  logic [1:0]  ERR_CODE;

  always #5 CLOCK = ~CLOCK;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .CLOCK       (CLOCK),
    .rst_n       (rst_n),
    .PS2_KBCLK   (PS2_KBCLK),
    .PS2_KBDAT   (PS2_KBDAT),
    .code_rd     (code_rd),
    .code_vector (code_vector),
    .code_valid  (code_valid),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .ERR_CODE    (ERR_CODE)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [15:0] exp_q[$];
  bit          m_ext, m_brk, m_ovf;
  logic [1:0]  m_err;

  function automatic void model_clear();
    exp_q.delete();
    m_ext = 0;
    m_brk = 0;
    m_ovf = 0;
    m_err = 2'b00;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit ok);
    logic [7:0] pre;
    if (!ok) begin
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      pre = (m_ext && m_brk) ? 8'hEF : m_ext ? 8'hE0 : m_brk ? 8'hF0 : 8'h00;
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({pre, b});
      else m_ovf = 1;
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  // bit 0 start, 1..8 data LSB first, 9 odd parity, 10 stop
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  // ---------------- line drivers ----------------
  task automatic send_bits(input logic [10:0] bits, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      PS2_KBDAT = bits[i];
      repeat (HALF) @(negedge CLOCK);
      PS2_KBCLK = 1'b0;
      repeat (HALF) @(negedge CLOCK);
      PS2_KBCLK = 1'b1;
    end
  endtask

  task automatic idle_gap();
    PS2_KBDAT = 1'b1;
    repeat (2 * HALF) @(negedge CLOCK);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(frame_bits(b, bad_par, bad_stop), 0, 10);
    idle_gap();
    model_frame(b, !bad_par && !bad_stop);
    m_err = bad_par ? 2'b01 : bad_stop ? 2'b10 : 2'b00;
  endtask

  task automatic clk_glitch(input int len);
    @(negedge CLOCK);
    PS2_KBCLK = 1'b0;
    repeat (len) @(negedge CLOCK);
    PS2_KBCLK = 1'b1;
  endtask

  // Samples the head and pops it when valid; called on a falling CLOCK edge.
  task automatic pop_head(output logic v, output logic [15:0] vec);
    v   = code_valid;
    vec = code_vector;
    if (v === 1'b1) begin
      code_rd = 1'b1;
      @(negedge CLOCK);
      code_rd = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    PS2_KBCLK = 1'b1;
    PS2_KBDAT = 1'b1;
    code_rd   = 1'b0;
    repeat (3) @(negedge CLOCK);
    rst_n = 1'b1;
    @(negedge CLOCK);
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (code_vector !== 16'h0000) begin
      n_bad++; $display("FAIL reset_vector: got %h want 0000", code_vector);
    end
    n_cmp++;
    if (code_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", code_valid);
    end
    n_cmp++;
    if (fifo_full !== 1'b0) begin
      n_bad++; $display("FAIL reset_full: got %b want 0", fifo_full);
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow);
    end
    n_cmp++;
    if (ERR_CODE !== 2'b00) begin
      n_bad++; $display("FAIL reset_err: got %b want 00", ERR_CODE);
    end
  endtask

  task automatic test_single();
    logic v;
    logic [15:0] vec;
    send_frame(8'h1C, 0, 0);
    n_cmp++;
    if (code_valid !== 1'b1 || code_vector !== 16'h001C) begin
      n_bad++; $display("FAIL single_code: got valid=%b %h want valid=1 001C", code_valid, code_vector);
    end
    n_cmp++;
    if (ERR_CODE !== m_err) begin
      n_bad++; $display("FAIL single_err: got %b want %b", ERR_CODE, m_err);
    end
    pop_head(v, vec);
    void'(exp_q.pop_front());
    n_cmp++;
    if (code_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_pop_valid: got %b want 0", code_valid);
    end
  endtask

  task automatic test_prefix();
    logic v;
    logic [15:0] vec, exp;
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    n_cmp++;
    if (exp_q.size() != 2 || exp_q[0] !== 16'hEF75 || exp_q[1] !== 16'hF01C) begin
      n_bad++; $display("FAIL prefix_model: got %0d entries want EF75,F01C", exp_q.size());
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      pop_head(v, vec);
      n_cmp++;
      if (v !== 1'b1 || vec !== exp) begin
        n_bad++; $display("FAIL prefix_code: got valid=%b %h want %h", v, vec, exp);
      end
    end
    n_cmp++;
    if (code_valid !== 1'b0) begin
      n_bad++; $display("FAIL prefix_extra: got valid=%b want 0", code_valid);
    end
  endtask

  task automatic test_parity();
    logic v;
    logic [15:0] vec, exp;
    send_frame(8'h1C, 1, 0);
    n_cmp++;
    if (code_valid !== 1'b0 || ERR_CODE !== 2'b01) begin
      n_bad++; $display("FAIL parity_err: got valid=%b err=%b want valid=0 err=01", code_valid, ERR_CODE);
    end
    send_frame(8'h32, 0, 0);
    n_cmp++;
    if (ERR_CODE !== 2'b00) begin
      n_bad++; $display("FAIL parity_recover_err: got %b want 00", ERR_CODE);
    end
    exp = exp_q.pop_front();
    pop_head(v, vec);
    n_cmp++;
    if (v !== 1'b1 || vec !== exp) begin
      n_bad++; $display("FAIL parity_recover_code: got valid=%b %h want %h", v, vec, exp);
    end
    send_frame(8'h44, 0, 1);
    n_cmp++;
    if (code_valid !== 1'b0 || ERR_CODE !== 2'b10) begin
      n_bad++; $display("FAIL stop_err: got valid=%b err=%b want valid=0 err=10", code_valid, ERR_CODE);
    end
  endtask

  task automatic test_overflow();
    logic v;
    logic [15:0] vec, exp;
    logic [7:0] b;
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hE0 || b == 8'hF0) b = 8'h11;
      send_frame(b, 0, 0);
    end
    n_cmp++;
    if (fifo_full !== 1'b1 || overflow !== m_ovf) begin
      n_bad++; $display("FAIL ovf_flags: got full=%b ovf=%b want full=1 ovf=%b", fifo_full, overflow, m_ovf);
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      exp = exp_q.pop_front();
      pop_head(v, vec);
      m_ovf = 0;
      n_cmp++;
      if (v !== 1'b1 || vec !== exp) begin
        n_bad++; $display("FAIL ovf_code%0d: got valid=%b %h want %h", i, v, vec, exp);
      end
      if (i == 0) begin
        n_cmp++;
        if (overflow !== 1'b0 || fifo_full !== 1'b0) begin
          n_bad++; $display("FAIL ovf_clear: got ovf=%b full=%b want 0 0", overflow, fifo_full);
        end
      end
    end
    n_cmp++;
    if (code_valid !== 1'b0) begin
      n_bad++; $display("FAIL ovf_drained: got valid=%b want 0", code_valid);
    end
  endtask

  task automatic test_glitch();
    logic v;
    logic [15:0] vec, exp;
    logic [10:0] bits;
    // Idle glitch with data low would start a frame if it were accepted.
    PS2_KBDAT = 1'b0;
    clk_glitch(FILTER_LEN - 1);
    repeat (10) @(negedge CLOCK);
    PS2_KBDAT = 1'b1;
    repeat (10) @(negedge CLOCK);
    bits = frame_bits(8'h3B, 0, 0);
    send_bits(bits, 0, 3);
    clk_glitch(FILTER_LEN - 1);
    repeat (5) @(negedge CLOCK);
    send_bits(bits, 4, 10);
    idle_gap();
    model_frame(8'h3B, 1);
    m_err = 2'b00;
    exp = exp_q.pop_front();
    pop_head(v, vec);
    n_cmp++;
    if (v !== 1'b1 || vec !== exp || ERR_CODE !== m_err) begin
      n_bad++; $display("FAIL glitch: got valid=%b %h err=%b want %h err=%b", v, vec, ERR_CODE, exp, m_err);
    end
    n_cmp++;
    if (code_valid !== 1'b0) begin
      n_bad++; $display("FAIL glitch_extra: got valid=%b want 0", code_valid);
    end
  endtask

  task automatic test_random();
    logic v;
    logic [15:0] vec, exp;
    logic [7:0] b;
    int kind;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      kind = int'($urandom_range(0, 9));
      send_frame(b, kind == 0, kind == 1);
      n_cmp++;
      if (ERR_CODE !== m_err) begin
        n_bad++; $display("FAIL rand_err%0d: byte %h got %b want %b", it, b, ERR_CODE, m_err);
      end
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        pop_head(v, vec);
        n_cmp++;
        if (v !== 1'b1 || vec !== exp) begin
          n_bad++; $display("FAIL rand_code%0d: got valid=%b %h want %h", it, v, vec, exp);
        end
      end else begin
        n_cmp++;
        if (code_valid !== 1'b0) begin
          n_bad++; $display("FAIL rand_nocode%0d: byte %h got valid=%b %h want 0", it, b, code_valid, code_vector);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic v;
    logic [15:0] vec, exp;
    send_frame(8'hE0, 0, 0);
    send_bits(frame_bits(8'hA5, 0, 0), 0, 4);
    rst_n = 1'b0;
    repeat (2) @(negedge CLOCK);
    rst_n = 1'b1;
    @(negedge CLOCK);
    model_clear();
    n_cmp++;
    if (code_valid !== 1'b0 || ERR_CODE !== 2'b00) begin
      n_bad++; $display("FAIL midreset_state: got valid=%b err=%b want 0 00", code_valid, ERR_CODE);
    end
    send_frame(8'h5A, 0, 0);
    exp = exp_q.pop_front();
    pop_head(v, vec);
    n_cmp++;
    if (v !== 1'b1 || vec !== exp) begin
      n_bad++; $display("FAIL midreset_code: got valid=%b %h want %h", v, vec, exp);
    end
  endtask

  task automatic test_timeout();
    logic v;
    logic [15:0] vec, exp;
    logic [10:0] bits;
    send_frame(8'hE0, 0, 0);
    bits = frame_bits(8'h1C, 0, 0);
    send_bits(bits, 0, 4);
    PS2_KBDAT = 1'b1;
    repeat (TIMEOUT_CYCLES + 50) @(negedge CLOCK);
`ifdef PS2_RX_TIMEOUT_EN
    model_frame(8'h1C, 0);
    m_err = 2'b11;
    n_cmp++;
    if (ERR_CODE !== m_err || code_valid !== 1'b0) begin
      n_bad++; $display("FAIL timeout_err: got err=%b valid=%b want err=11 valid=0", ERR_CODE, code_valid);
    end
    send_frame(8'h1C, 0, 0);
`else
    n_cmp++;
    if (ERR_CODE !== m_err || code_valid !== 1'b0) begin
      n_bad++; $display("FAIL no_timeout_err: got err=%b valid=%b want err=%b valid=0", ERR_CODE, code_valid, m_err);
    end
    send_bits(bits, 5, 10);
    idle_gap();
    model_frame(8'h1C, 1);
`endif
    exp = exp_q.pop_front();
    pop_head(v, vec);
    n_cmp++;
    if (v !== 1'b1 || vec !== exp || ERR_CODE !== 2'b00) begin
      n_bad++; $display("FAIL timeout_after: got valid=%b %h err=%b want %h err=00", v, vec, ERR_CODE, exp);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_overflow();
    test_glitch();
    test_random();
    test_reset_midframe();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
